// File: rtl/poly_fg_keygen_seq.sv
// poly_fg_keygen_seq
// Drives the shared Gaussian sampler twice per key attempt (f, then g),
// streams each accepted coefficient to the coefficient buffer and, when
// POLY_FG_SEQ_NORM_CHECK_EN is defined, accumulates ||f||^2 + ||g||^2 and
// rejects/restarts the attempt when the norm reaches NORM_BOUND.
// Without the macro, CHECK always accepts and retry_cnt is tied to 0.
//
// Handshake: the sampler offers a coefficient with smp_valid; every cycle
// in GEN_F/GEN_G with smp_valid high is an accept (there is no ready
// back-pressure, gen_ena is the only flow control toward the sampler).
module poly_fg_keygen_seq #(
  parameter int LOGN       = 9,
  parameter int NORM_BOUND = 16823
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  output logic            gen_ena,
  input  logic            smp_valid,
  input  logic [7:0]      smp,
  output logic            wr_en,
  output logic            wr_sel,
  output logic [LOGN-1:0] wr_addr,
  output logic [7:0]      wr_data,
  output logic            busy,
  output logic            done,
  output logic [7:0]      retry_cnt,
  output logic [2:0]      dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GEN_F = 3'd1,
    S_GAP   = 3'd2,
    S_GEN_G = 3'd3,
    S_CHECK = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [LOGN-1:0] idx_q;
  logic            gap_to_g_q;   // 1: GAP returns to GEN_G, 0: GAP returns to GEN_F
  logic            accept;
  logic            last_idx;
  logic            start_go;
  logic            norm_ok;
  logic            gen_ena_d, done_d, wr_en_d;

  assign accept   = ((state_q == S_GEN_F) || (state_q == S_GEN_G)) && smp_valid;
  assign last_idx = &idx_q;
  assign start_go = (state_q == S_IDLE) && start && !abort;
  assign dbg_state = state_q;

`ifdef POLY_FG_SEQ_NORM_CHECK_EN
  logic [24:0] acc_q;
  logic [7:0]  retry_q;
  logic [7:0]  smp_mag;
  logic [15:0] smp_sq;

  // Magnitude of the signed sample; -128 maps to 128, so the square is at most 16384
  assign smp_mag   = smp[7] ? (8'd0 - smp) : smp;
  assign smp_sq    = 16'(smp_mag) * 16'(smp_mag);
  assign norm_ok   = (acc_q < 25'(NORM_BOUND));
  assign retry_cnt = retry_q;

  // Norm accumulator and saturating reject counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      retry_q <= '0;
    end else if (start_go) begin
      acc_q   <= '0;
      retry_q <= '0;
    end else if ((state_q == S_CHECK) && !norm_ok && !abort) begin
      acc_q   <= '0;
      retry_q <= (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
    end else if (accept) begin
      acc_q   <= acc_q + 25'(smp_sq);
    end
  end
`else
  assign norm_ok   = 1'b1;
  assign retry_cnt = 8'd0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; abort overrides every transition
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start) state_d = S_GEN_F;
        S_GEN_F: if (accept && last_idx) state_d = S_GAP;
        S_GAP:   state_d = gap_to_g_q ? S_GEN_G : S_GEN_F;
        S_GEN_G: if (accept && last_idx) state_d = S_CHECK;
        S_CHECK: state_d = norm_ok ? S_DONE : S_GAP;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output decode; strobes are derived from the next state and registered below
  always_comb begin
    busy      = (state_q != S_IDLE);
    gen_ena_d = (state_d == S_GEN_F) || (state_d == S_GEN_G);
    done_d    = (state_d == S_DONE);
    wr_en_d   = accept && !abort;
  end

  // Registered outputs toward the sampler and the coefficient buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gen_ena <= 1'b0;
      done    <= 1'b0;
      wr_en   <= 1'b0;
      wr_sel  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      gen_ena <= gen_ena_d;
      done    <= done_d;
      wr_en   <= wr_en_d;
      if (accept) begin
        wr_sel  <= (state_q == S_GEN_G);
        wr_addr <= idx_q;
        wr_data <= smp;
      end
    end
  end

  // Coefficient index (wraps naturally at n-1) and GAP return target
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q      <= '0;
      gap_to_g_q <= 1'b0;
    end else begin
      if (start_go)    idx_q <= '0;
      else if (accept) idx_q <= idx_q + 1'b1;

      if ((state_q == S_GEN_F) && accept && last_idx && !abort) gap_to_g_q <= 1'b1;
      else if ((state_q == S_CHECK) && !abort)                  gap_to_g_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_poly_fg_keygen_seq.sv
// Directed testbench for poly_fg_keygen_seq at LOGN=2, NORM_BOUND=10.
// Expectations follow POLY_FG_SEQ_NORM_CHECK_EN when it is defined.
module tb_poly_fg_keygen_seq;

  localparam int LOGN = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic            gen_ena;
  logic            smp_valid = 1'b0;
  logic [7:0]      smp = 8'd0;
  logic            wr_en;
  logic            wr_sel;
  logic [LOGN-1:0] wr_addr;
  logic [7:0]      wr_data;
  logic            busy;
  logic            done;
  logic [7:0]      retry_cnt;
  logic [2:0]      dbg_state;

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;
  logic [10:0] exp_q[$];   // {sel, addr, data}

  poly_fg_keygen_seq #(.LOGN(LOGN), .NORM_BOUND(10)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .gen_ena(gen_ena),
    .smp_valid(smp_valid), .smp(smp), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .retry_cnt(retry_cnt), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, " gen_ena"}, gen_ena, 0);
    chk({nm, " wr_en"}, wr_en, 0);
    chk({nm, " wr_sel"}, wr_sel, 0);
    chk({nm, " wr_addr"}, wr_addr, 0);
    chk({nm, " wr_data"}, wr_data, 0);
    chk({nm, " busy"}, busy, 0);
    chk({nm, " done"}, done, 0);
    chk({nm, " retry_cnt"}, retry_cnt, 0);
  endtask

  // Drive one cycle of inputs, return at the next negedge
  task automatic cyc(input logic st, input logic v, input logic [7:0] d, input logic ab);
    start = st; smp_valid = v; smp = d; abort = ab;
    @(negedge clk);
  endtask

  // Scoreboard: every write strobe must match the oldest expected accept
  always @(posedge clk) begin
    #1;
    if (mon_en && wr_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write actual=sel%0d/addr%0d/data%0d required=no write",
                 wr_sel, wr_addr, wr_data);
      end else begin
        logic [10:0] e;
        e = exp_q.pop_front();
        if ({wr_sel, wr_addr, wr_data} !== e) begin
          errors++;
          $display("FAIL write actual=sel%0d/addr%0d/data%0d required=sel%0d/addr%0d/data%0d",
                   wr_sel, wr_addr, wr_data, e[10], e[9:8], e[7:0]);
        end
      end
    end
  end

  typedef struct {
    logic            st;       // 1: begins with start from IDLE, 0: continues after a reject
    logic [3:0][7:0] f;
    logic [3:0][7:0] g;
    logic            acc_ok;   // pair accepted at CHECK
    logic [7:0]      retry;    // retry_cnt after CHECK
  } vec_t;

  vec_t vecs[5];
  logic [7:0] prev_retry = 8'd0;

  // One attempt with smp_valid held high; on accept it ends in IDLE, on reject in GAP
  task automatic run_attempt(input vec_t e, input int id);
    string tag;
    tag = $sformatf("v%0d", id);
    if (e.st) begin
      chk({tag, " lead busy"}, busy, 0);
    end else begin
      chk({tag, " gap busy"}, busy, 1);
      chk({tag, " retry after reject"}, retry_cnt, prev_retry);
    end
    chk({tag, " lead gen_ena"}, gen_ena, 0);
    cyc(e.st, 1'b1, 8'h55, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk({tag, " f gen_ena"}, gen_ena, 1);
      chk({tag, " f done"}, done, 0);
      exp_q.push_back({1'b0, 2'(i), e.f[i]});
      cyc(1'b0, 1'b1, e.f[i], 1'b0);
    end
    chk({tag, " gap gen_ena"}, gen_ena, 0);
    chk({tag, " gap busy"}, busy, 1);
    cyc(1'b0, 1'b1, 8'h66, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk({tag, " g gen_ena"}, gen_ena, 1);
      exp_q.push_back({1'b1, 2'(i), e.g[i]});
      cyc(1'b0, 1'b1, e.g[i], 1'b0);
    end
    chk({tag, " check gen_ena"}, gen_ena, 0);
    chk({tag, " check done"}, done, 0);
    cyc(1'b0, 1'b1, 8'h77, 1'b0);
    chk({tag, " outcome done"}, done, e.acc_ok);
    if (e.acc_ok) begin
      chk({tag, " retry_cnt"}, retry_cnt, e.retry);
      cyc(1'b0, 1'b0, 8'd0, 1'b0);
      chk({tag, " done pulse ends"}, done, 0);
      chk({tag, " idle busy"}, busy, 0);
      chk({tag, " all writes seen"}, exp_q.size(), 0);
    end
    prev_retry = e.retry;
  endtask

  initial begin
    vec_t fresh;
    int acc_n;
    int k;
    logic [7:0] fs[4];
    logic [7:0] gs[4];

    // Hand-computed vectors, bound 10
    vecs[0] = '{st: 1'b1, f: {8'd0, 8'd2, 8'hFF, 8'd1}, g: {8'hFF, 8'd1, 8'd1, 8'd0},
                acc_ok: 1'b1, retry: 8'd0};                       // norm 9
`ifdef POLY_FG_SEQ_NORM_CHECK_EN
    vecs[1] = '{st: 1'b1, f: {8'd0, 8'd0, 8'd0, 8'd3}, g: {8'd0, 8'd0, 8'd0, 8'd1},
                acc_ok: 1'b0, retry: 8'd1};                       // norm 10 rejected
    vecs[2] = '{st: 1'b0, f: '0, g: '0, acc_ok: 1'b1, retry: 8'd1};
    vecs[3] = '{st: 1'b1, f: {8'd0, 8'd0, 8'd127, 8'h80}, g: {8'd0, 8'd0, 8'd0, 8'd5},
                acc_ok: 1'b0, retry: 8'd1};                       // norm 32538, counter restarted
    vecs[4] = '{st: 1'b0, f: {8'd1, 8'd0, 8'd0, 8'd0}, g: {8'd0, 8'hFE, 8'd0, 8'd0},
                acc_ok: 1'b1, retry: 8'd1};                       // norm 5
`else
    vecs[1] = '{st: 1'b1, f: {8'd0, 8'd0, 8'd0, 8'd3}, g: {8'd0, 8'd0, 8'd0, 8'd1},
                acc_ok: 1'b1, retry: 8'd0};
    vecs[2] = '{st: 1'b1, f: '0, g: '0, acc_ok: 1'b1, retry: 8'd0};
    vecs[3] = '{st: 1'b1, f: {8'd0, 8'd0, 8'd127, 8'h80}, g: {8'd0, 8'd0, 8'd0, 8'd5},
                acc_ok: 1'b1, retry: 8'd0};
    vecs[4] = '{st: 1'b1, f: {8'd1, 8'd0, 8'd0, 8'd0}, g: {8'd0, 8'hFE, 8'd0, 8'd0},
                acc_ok: 1'b1, retry: 8'd0};
`endif

    // Reset block
    repeat (2) @(negedge clk);
    chk_reset_vals("in_reset");
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("after_reset");
    mon_en = 1'b1;

    // Table-driven attempts
    for (int i = 0; i < 5; i++) run_attempt(vecs[i], i);

    // Stalled sampler: valid every third cycle, f = 1,0,0,1 and g = 0,1,0,0
    fs = '{8'd1, 8'd0, 8'd0, 8'd1};
    gs = '{8'd0, 8'd1, 8'd0, 8'd0};
    cyc(1'b1, 1'b0, 8'd0, 1'b0);
    acc_n = 0; k = 0;
    while (acc_n < 4 && k < 20) begin
      chk("stall f gen_ena", gen_ena, 1);
      if (k % 3 == 2) begin
        exp_q.push_back({1'b0, 2'(acc_n), fs[acc_n]});
        cyc(1'b0, 1'b1, fs[acc_n], 1'b0);
        acc_n++;
      end else begin
        cyc(1'b0, 1'b0, 8'd77, 1'b0);
      end
      k++;
    end
    chk("stall gap gen_ena", gen_ena, 0);
    cyc(1'b0, 1'b0, 8'd77, 1'b0);
    acc_n = 0; k = 0;
    while (acc_n < 4 && k < 20) begin
      chk("stall g gen_ena", gen_ena, 1);
      if (k % 3 == 2) begin
        exp_q.push_back({1'b1, 2'(acc_n), gs[acc_n]});
        cyc(1'b0, 1'b1, gs[acc_n], 1'b0);
        acc_n++;
      end else begin
        cyc(1'b0, 1'b0, 8'd77, 1'b0);
      end
      k++;
    end
    chk("stall check busy", busy, 1);
    cyc(1'b0, 1'b0, 8'd0, 1'b0);
    chk("stall done", done, 1);
    cyc(1'b0, 1'b0, 8'd0, 1'b0);
    chk("stall idle", busy, 0);
    chk("stall writes seen", exp_q.size(), 0);

    // Abort during GEN_G at index 2
    cyc(1'b1, 1'b0, 8'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({1'b0, 2'(i), 8'(i + 1)});
      cyc(1'b0, 1'b1, 8'(i + 1), 1'b0);
    end
    cyc(1'b0, 1'b0, 8'd0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({1'b1, 2'(i), 8'(i + 1)});
      cyc(1'b0, 1'b1, 8'(i + 1), 1'b0);
    end
    cyc(1'b0, 1'b1, 8'd9, 1'b1);
    chk("abort busy", busy, 0);
    chk("abort gen_ena", gen_ena, 0);
    chk("abort wr_en", wr_en, 0);
    chk("abort done", done, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 8'd0, 1'b0);
      chk("post abort done", done, 0);
      chk("post abort busy", busy, 0);
    end
    chk("abort writes seen", exp_q.size(), 0);
    fresh = '{st: 1'b1, f: {8'd0, 8'd0, 8'd0, 8'hFE}, g: {8'd0, 8'd0, 8'd1, 8'd0},
              acc_ok: 1'b1, retry: 8'd0};
    run_attempt(fresh, 9);

    // Asynchronous reset in the middle of GEN_G
    mon_en = 1'b0;
    cyc(1'b1, 1'b0, 8'd0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'd3, 1'b0);
    cyc(1'b0, 1'b0, 8'd0, 1'b0);
    cyc(1'b0, 1'b1, 8'd2, 1'b0);
    cyc(1'b0, 1'b1, 8'd2, 1'b0);
    chk("pre reset busy", busy, 1);
    rst = 1'b1;
    #1;
    chk_reset_vals("async_reset");
    smp_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 8'd0, 1'b0);
      chk("post reset busy", busy, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/poly_fg_keygen_seq.md
# poly_fg_keygen_seq

Sequencer that drives the shared small-polynomial Gaussian sampler twice per key attempt, producing f and then g. It streams every accepted coefficient to the coefficient buffer write port and accumulates the squared norm of (f, g). It then accepts the pair or restarts the attempt. It sits between the keygen top-level control and the sampler / coefficient RAM.

## Interface
Parameters:
- LOGN, 9, log2 of polynomial degree; n = 1 << LOGN.
- NORM_BOUND, 16823, reject when ||f||² + ||g||² ≥ NORM_BOUND.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a keygen attempt; honoured only in IDLE.
- abort  in  1  synchronous abort; highest priority after rst.
- gen_ena  out  1  enable to the sampler (registered).
- smp_valid  in  1  sampler coefficient valid.
- smp  in  8  sampler coefficient, signed two's complement.
- wr_en  out  1  coefficient buffer write strobe (registered).
- wr_sel  out  1  0 = f bank, 1 = g bank.
- wr_addr  out  LOGN  coefficient index.
- wr_data  out  8  signed coefficient.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the (f, g) pair is accepted.
- retry_cnt  out  8  rejected attempts since the last start; saturates at 255.

## Operation
- States: IDLE, GEN_F, GAP, GEN_G, CHECK, DONE.
- IDLE: on start go to GEN_F. Clear the index, clear the 25-bit norm accumulator, clear retry_cnt.
- GEN_F / GEN_G: each cycle with smp_valid high is an accept.
  - An accept writes smp to the index, adds smp² (unsigned, at most 16384) to the accumulator, and increments the index.
  - The accept at index n-1 wraps the index to 0.
  - From GEN_F that accept moves to GAP. From GEN_G it moves to CHECK.
- GAP: exactly 1 cycle with gen_ena low, which re-arms the sampler. Then go to GEN_G.
- CHECK: 1 cycle.
  - If acc < NORM_BOUND, go to DONE.
  - Otherwise increment retry_cnt (saturating), clear acc, and go through GAP to GEN_F. This GAP returns to GEN_F, not GEN_G.
  - GAP tracks its return target with one bit.
- DONE: 1 cycle, done = 1, then IDLE.
- smp_valid outside GEN_F/GEN_G is ignored: no write, no accumulation.
- start outside IDLE is ignored.
- abort in any state: IDLE next cycle, with gen_ena, wr_en and done all 0. retry_cnt holds its value. No partial done.
- Accumulator width: 25 bits, enough for 2n·16384 at LOGN ≤ 9. No overflow is possible.

## Timing
- Reset values: gen_ena 0, wr_en 0, wr_sel 0, wr_addr 0, wr_data 0, busy 0, done 0, retry_cnt 0; state IDLE; acc 0.
- gen_ena = 1 from the cycle after start is sampled. It drops the cycle after the last accept of each polynomial.
- wr_en, wr_sel, wr_addr and wr_data appear 1 cycle after the accept.
- done asserts 2 cycles after the final g accept (CHECK, then DONE).
- Minimum attempt latency: start → done = 2n + 4 cycles with smp_valid held high. This is 1 (enter GEN_F) + n + 1 (GAP) + n + 1 (CHECK) + 1 (DONE).
- A reject adds 2 cycles (CHECK, GAP) plus the new generation time.

## Configuration
- POLY_FG_SEQ_NORM_CHECK_EN defined:
  - The accumulator and the comparison are present.
  - CHECK accepts or rejects as described above.
- Undefined:
  - No accumulator logic is built.
  - CHECK always proceeds to DONE.
  - retry_cnt is tied to 0.

## Test plan
- Reset, then idle: assert rst mid-GEN_G → all outputs at their reset values immediately; after release, busy = 0 until start.
- Accept path (LOGN=2, macro on):
  - Stimulus: start, f = 1,-1,2,0, then g = 0,1,1,-1, smp_valid held high.
  - Writes: sel 0 at addr 0..3, then sel 1 at addr 0..3.
  - Norm 9 < 16823 → done pulse at cycle 12 after start; retry_cnt = 0.
- Reject path (LOGN=2, NORM_BOUND=10):
  - First attempt: f = 3,0,0,0 and g = 1,0,0,0 gives norm 10 → rejected, retry_cnt = 1, next write is sel 0 addr 0.
  - Second attempt: all-zero f and g → done.
- Stalled sampler: smp_valid high every third cycle → wr_addr advances only on accepts; wr_en never fires without a matching accept; gen_ena stays high through GEN_F.
- Abort: abort during GEN_G at index 2 → IDLE next cycle, busy = 0, no done. A fresh start then completes normally with writes from addr 0.
- Macro off: same stimulus as the reject path → done after the first attempt; retry_cnt = 0.
